// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction fetch / instruction register and
// run/stop control. It is stepped by the 5-phase one-hot sequencer bus, and
// start/stop requests only take effect on instruction boundaries.
module fetch_unit #(
    parameter int ADDR_W   = 12,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         phase_bus,
    input  logic               exec,
    input  logic               halt_req,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic               running,
    output logic               retire,
    output logic [CNT_W-1:0]   retired_cnt,
    output logic               phase_err
);

    typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    state_t state, state_nxt;
    logic   exec_q;
    logic   start_pend;
    logic   stop_pend;
    logic   phase_ok;
    logic   exec_edge;
    logic   start_now;
    logic   step_now;
    logic   stop_now;

    // A cycle whose phase bus is not exactly one-hot (including all-zero while
    // the sequencer is still held in reset) does nothing, and its exec edge is lost.
    assign phase_ok  = $onehot(phase_bus);
    assign exec_edge = exec & ~exec_q & phase_ok;

    // The start is taken on P0 so that this instruction's fetch uses the same P0.
    assign start_now = (state == ST_STOP) & phase_ok & phase_bus[0] & (start_pend | exec_edge);
    // A P4 in RUN always finishes the instruction, even when a stop comes with it.
    assign step_now  = (state == ST_RUN) & phase_ok & phase_bus[4];
    assign stop_now  = step_now & (halt_req | stop_pend | exec_edge);

    // Instruction memory is read synchronously, so the address is the live PC.
    assign imem_addr = pc;
    assign running   = (state == ST_RUN);

    // Run/stop state register
    always_ff @(posedge clock) begin
        if (!reset) state <= ST_STOP;
        else        state <= state_nxt;
    end

    // Next-state: start on a boundary P0, stop after a boundary P4
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: if (start_now) state_nxt = ST_RUN;
            ST_RUN:  if (stop_now)  state_nxt = ST_STOP;
            default: state_nxt = ST_STOP;
        endcase
    end

    // Pending start/stop requests, held until the next instruction boundary
    always_ff @(posedge clock) begin
        if (!reset) begin
            start_pend <= 1'b0;
            stop_pend  <= 1'b0;
        end else begin
            if (start_now)
                start_pend <= 1'b0;
            else if ((state == ST_STOP) && exec_edge)
                start_pend <= 1'b1;

            if (stop_now)
                stop_pend <= 1'b0;
            else if ((state == ST_RUN) && exec_edge)
                stop_pend <= 1'b1;
        end
    end

    // PC, instruction register, retire bookkeeping and the phase-error flag.
    // exec_q resets to 1 so an exec held across reset needs a fresh press.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc          <= PC_INIT;
            instr       <= '0;
            retire      <= 1'b0;
            retired_cnt <= '0;
            phase_err   <= 1'b0;
            exec_q      <= 1'b1;
        end else begin
            exec_q    <= exec;
            phase_err <= ~phase_ok;
            retire    <= step_now;
            if ((state == ST_RUN) && phase_ok && phase_bus[1])
                instr <= imem_data;
            if (step_now) begin
                pc          <= branch_taken ? branch_target : pc + ADDR_W'(1);
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

endmodule
